// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder slice.
//
// Contents:
//   DEFAULT_WIDTH / DEFAULT_CHUNK : default operand width and bits added per cycle
//   state_e                       : controller states (IDLE=0, CALC=1, DONE=2)
//   count_width()                 : width of a counter that must hold 0..n inclusive
package multi_cycle_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(n+1)): enough bits to represent every value from 0 to n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multi_cycle_adder_chunk_adder.sv
// Ripple-carry building blocks for the multi-cycle adder.
//
// half_adder  : a, b -> s = a^b, c = a&b
// chunk_adder : CHUNK-bit ripple adder built from half_adder cells
//   x, y  : CHUNK-bit addends
//   ci    : carry into bit 0
//   s     : CHUNK-bit sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (used for signed overflow on the last chunk)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // c[i] is the carry into bit i; c[CHUNK] is the carry out of the chunk.
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] h;

  assign c[0] = ci;

  // A full adder is two half adders; their carries can never both be 1,
  // so OR-ing them gives the bit's carry out.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    half_adder u_ha_xy (
      .a(x[i]),
      .b(y[i]),
      .s(p[i]),
      .c(g[i])
    );
    half_adder u_ha_ci (
      .a(p[i]),
      .b(c[i]),
      .s(s[i]),
      .c(h[i])
    );
    assign c[i+1] = g[i] | h[i];
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock over WIDTH/CHUNK cycles.
//
// Ports:
//   clk, rst_n          : clock (rising edge) and asynchronous active-low reset
//   a, b                : WIDTH-bit operands, sampled only when a request is accepted
//   cin                 : carry-in for addition (ignored when sub=1)
//   sub                 : 0 -> a+b+cin, 1 -> a-b
//   in_valid / in_ready : request handshake; in_ready is high only while idle
//   sum, cout, ovf      : result, final carry (sub=1: 1 means no borrow), signed overflow
//   out_valid/out_ready : result handshake; the result holds until taken
//
// sum/cout/ovf only change when a computation completes, so they keep the
// previous result while idle and while the next one is being computed.
module multi_cycle_adder
  import multi_cycle_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = count_width(NCHUNK);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             chunk_c_msb;
  logic [WIDTH-1:0] chunk_s_ext;

  // Both working registers are rotated right by one chunk every CALC cycle,
  // so chunk k is always found in the low bits and no variable part-select
  // is needed. Each new partial sum enters at the top of acc, and after
  // NCHUNK cycles chunk 0 of the result has been shifted back to bit 0.
  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .x    (acc_q[CHUNK-1:0]),
    .y    (opb_q[CHUNK-1:0]),
    .ci   (carry_q),
    .s    (chunk_s),
    .co   (chunk_co),
    .c_msb(chunk_c_msb)
  );

  assign chunk_s_ext = WIDTH'(chunk_s);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    k_d     = k_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + 1, so invert b and seed the carry with 1.
          acc_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        acc_d   = (acc_q >> CHUNK) | (chunk_s_ext << (WIDTH - CHUNK));
        opb_d   = opb_q >> CHUNK;
        carry_d = chunk_co;
        k_d     = k_q + 1'b1;
        if (k_q == KW'(NCHUNK - 1)) begin
          sum_d   = acc_d;
          cout_d  = chunk_co;
          ovf_d   = chunk_c_msb ^ chunk_co;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench for multi_cycle_adder.
// Two instances run side by side: index 0 is WIDTH=16/CHUNK=4, index 1 is
// WIDTH=16/CHUNK=16. A transaction-level model predicts every output on every
// cycle; directed cases pin the model with hand-computed literal results.
module tb_multi_cycle_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0][W-1:0] a;
  logic [1:0][W-1:0] b;
  logic [1:0]        cin;
  logic [1:0]        sub;
  logic [1:0]        in_valid;
  logic [1:0]        out_ready;
  wire  [1:0][W-1:0] sum;
  wire  [1:0]        cout;
  wire  [1:0]        ovf;
  wire  [1:0]        in_ready;
  wire  [1:0]        out_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model state: per instance, whether a request is outstanding, the cycle it
  // was accepted, the result it will produce and the result shown before it.
  int           nchunk [2] = '{4, 1};
  bit           pend [2];
  int           acc_cyc [2];
  logic [W+1:0] res [2];
  logic [W+1:0] prev [2];

  logic         cmp_ev;
  logic [W+1:0] cmp_eo;

  always #5 clk = ~clk;

  multi_cycle_adder #(
    .WIDTH(W),
    .CHUNK(4)
  ) dut_c4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a[0]),
    .b        (b[0]),
    .cin      (cin[0]),
    .sub      (sub[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .sum      (sum[0]),
    .cout     (cout[0]),
    .ovf      (ovf[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0])
  );

  multi_cycle_adder #(
    .WIDTH(W),
    .CHUNK(16)
  ) dut_c16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a[1]),
    .b        (b[1]),
    .cin      (cin[1]),
    .sub      (sub[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .sum      (sum[1]),
    .cout     (cout[1]),
    .ovf      (ovf[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1])
  );

  // Arithmetic reference: returns {ovf, cout, sum} from plain integer rules.
  function automatic logic [W+1:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci, input logic sb);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    if (sb) begin
      r  = x - y;
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r    = full[W-1:0];
      co   = full[W];
      ov   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {ov, co, r};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input int u, input logic [W+1:0] got,
                       input logic [W+1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d at cycle %0d: got %h, expected %h", name, u, cyc, got, exp);
    end
  endtask

  // Transaction-level model: accept when idle and in_valid, result visible
  // NCHUNK edges later, released on any later edge with out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int u = 0; u < 2; u++) begin
        pend[u]    <= 1'b0;
        acc_cyc[u] <= 0;
        res[u]     <= '0;
        prev[u]    <= '0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int u = 0; u < 2; u++) begin
        if (!pend[u]) begin
          if (in_valid[u]) begin
            pend[u]    <= 1'b1;
            acc_cyc[u] <= cyc + 1;
            prev[u]    <= res[u];
            res[u]     <= ref_result(a[u], b[u], cin[u], sub[u]);
          end
        end else if (cyc >= acc_cyc[u] + nchunk[u] && out_ready[u]) begin
          pend[u] <= 1'b0;
        end
      end
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int u = 0; u < 2; u++) begin
        cmp_ev = pend[u] && (cyc >= acc_cyc[u] + nchunk[u]);
        cmp_eo = (pend[u] && !cmp_ev) ? prev[u] : res[u];
        check("cyc_out_valid", u, (W+2)'(out_valid[u]), (W+2)'(cmp_ev));
        check("cyc_in_ready", u, (W+2)'(in_ready[u]), (W+2)'(!pend[u]));
        check("cyc_result", u, {ovf[u], cout[u], sum[u]}, cmp_eo);
      end
    end
  end

  // Called at a falling edge (or just after); waits for in_ready, presents one
  // request for one edge, then scrambles the inputs so later changes are visible.
  task automatic applyStimulus(input int u, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic sb);
    int t = 0;
    while (in_ready[u] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", u, (W+2)'(in_ready[u]), (W+2)'(1'b1));
    a[u]        = x;
    b[u]        = y;
    cin[u]      = ci;
    sub[u]      = sb;
    in_valid[u] = 1'b1;
    @(negedge clk);
    in_valid[u] = 1'b0;
    a[u]        = W'($urandom);
    b[u]        = W'($urandom);
    cin[u]      = 1'($urandom);
    sub[u]      = 1'($urandom);
  endtask

  // Called straight after applyStimulus: checks latency and the literal result,
  // optionally stalls with in_valid noise, then releases the result.
  task automatic checkOutput(input int u, input string name, input logic [W-1:0] es,
                             input logic ec, input logic eov, input int stall);
    int n = 0;
    while (out_valid[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, u, (W+2)'(n), (W+2)'(nchunk[u]));
    check({name, "_result"}, u, {ovf[u], cout[u], sum[u]}, {eov, ec, es});
    for (int i = 0; i < stall; i++) begin
      in_valid[u] = 1'($urandom);
      a[u]        = W'($urandom);
      b[u]        = W'($urandom);
      sub[u]      = 1'($urandom);
      @(negedge clk);
    end
    in_valid[u] = 1'b0;
    if (stall > 0) begin
      check({name, "_held"}, u, {ovf[u], cout[u], sum[u]}, {eov, ec, es});
      check({name, "_held_hs"}, u, (W+2)'({out_valid[u], in_ready[u]}), (W+2)'(2'b10));
    end
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    check({name, "_released"}, u, (W+2)'({out_valid[u], in_ready[u]}), (W+2)'(2'b01));
  endtask

  task automatic runRandom(input int u, input int count);
    int n;
    int stall;
    for (int i = 0; i < count; i++) begin
      applyStimulus(u, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      n = 0;
      while (out_valid[u] !== 1'b1 && n < 50) begin
        in_valid[u] = 1'($urandom);
        @(negedge clk);
        n++;
      end
      stall = $urandom_range(0, 3);
      for (int j = 0; j < stall; j++) begin
        in_valid[u] = 1'($urandom);
        a[u]        = W'($urandom);
        @(negedge clk);
      end
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
      @(negedge clk);
      out_ready[u] = 1'b0;
    end
  endtask

  task automatic checkResetState(input string name);
    for (int u = 0; u < 2; u++) begin
      check({name, "_hs"}, u, (W+2)'({out_valid[u], in_ready[u]}), (W+2)'(2'b01));
      check({name, "_result"}, u, {ovf[u], cout[u], sum[u]}, '0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    cin       = '0;
    sub       = '0;
    in_valid  = '0;
    out_ready = '0;
    #1;
    checkResetState("reset");
    repeat (2) @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    for (int u = 0; u < 2; u++) begin
      applyStimulus(u, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      checkOutput(u, "add_ripple", 16'h0100, 1'b0, 1'b0, 0);
      applyStimulus(u, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      checkOutput(u, "add_wrap", 16'h0000, 1'b1, 1'b0, 0);
      applyStimulus(u, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      checkOutput(u, "add_ovf", 16'h8000, 1'b0, 1'b1, 0);
      applyStimulus(u, 16'h0005, 16'h0007, 1'b1, 1'b1);
      checkOutput(u, "sub_borrow", 16'hFFFE, 1'b0, 1'b0, 0);
      applyStimulus(u, 16'h8000, 16'h0001, 1'b0, 1'b1);
      checkOutput(u, "sub_ovf_stall", 16'h7FFF, 1'b1, 1'b1, 10);

      // Abort a computation one edge into it with an asynchronous reset.
      applyStimulus(u, 16'hABCD, 16'h1357, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetState("async_reset");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(u, 16'h1234, 16'h1111, 1'b0, 1'b0);
      checkOutput(u, "after_reset", 16'h2345, 1'b0, 1'b0, 0);

      runRandom(u, 40);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit (tests %0d, failed %0d)", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
